// File: rtl/nova_bs_pkg.sv
// Shared constants and FSM encoding for the bitstream fetch path.
package nova_bs_pkg;

  localparam int unsigned BS_WORD_W      = 16;
  localparam int unsigned BS_BUF_W       = 48;
  localparam int unsigned BS_MAX_CONSUME = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } bsState_t;

  // Accepted consume length: request clipped to one window and to what is buffered.
  function automatic logic [4:0] clipLen(input logic [4:0] req, input logic [5:0] avail);
    logic [5:0] lim;
    lim = (req > 5'(BS_MAX_CONSUME)) ? 6'(BS_MAX_CONSUME) : 6'(req);
    return (lim > avail) ? 5'(avail) : 5'(lim);
  endfunction

endpackage

// File: rtl/bs_shift_buffer.sv
// 48-bit MSB-justified bit buffer: shift out consumed bits, append a new word below the survivors.
module bs_shift_buffer
  import nova_bs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [4:0]           shiftLen,
  input  logic                 insertEn,
  input  logic [BS_WORD_W-1:0] insertWord,
  output logic [BS_WORD_W-1:0] window,
  output logic [5:0]           bitCnt
);

  logic [BS_BUF_W-1:0] bufReg;
  logic [BS_BUF_W-1:0] shifted;
  logic [BS_BUF_W-1:0] placed;
  logic [BS_BUF_W-1:0] bufNext;
  logic [5:0]          keptCnt;
  logic [5:0]          cntNext;

  always_comb begin
    shifted = bufReg << shiftLen;
    keptCnt = bitCnt - 6'(shiftLen);
    // New word lands directly below the bits that survive this cycle's shift.
    placed  = {insertWord, {(BS_BUF_W-BS_WORD_W){1'b0}}} >> keptCnt;
    bufNext = shifted;
    cntNext = keptCnt;
    if (insertEn) begin
      bufNext = shifted | placed;
      cntNext = keptCnt + 6'(BS_WORD_W);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bufReg <= '0;
      bitCnt <= '0;
    end else begin
      bufReg <= bufNext;
      bitCnt <= cntNext;
    end
  end

  assign window = bufReg[BS_BUF_W-1 -: BS_WORD_W];

endmodule

// File: rtl/bitstream_fetch_ctrl.sv
// Bitstream RAM read initiator: paces word reads to keep the bit buffer full for the parser.
module bitstream_fetch_ctrl
  import nova_bs_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 17'h1FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  output logic                 BitStream_ram_ren,
  output logic [ADDR_W-1:0]    BitStream_ram_addr,
  input  logic [BS_WORD_W-1:0] BitStream_ram_data,
  output logic [BS_WORD_W-1:0] bits_window,
  output logic                 window_valid,
  input  logic                 consume_en,
  input  logic [4:0]           consume_len,
  output logic [5:0]           bit_cnt,
  output logic                 fetch_done,
  output logic                 stream_end
);

  bsState_t          state, stateNext;
  logic              pending;
  logic              doneReg;
  logic [ADDR_W-1:0] addrReg;
  logic              accept;
  logic [4:0]        acceptLen;
  logic [6:0]        committed;
  logic              issue;
  logic              lastIssue;

  assign window_valid = (bit_cnt >= 6'(BS_WORD_W)) || (doneReg && (bit_cnt != '0));
  assign stream_end   = doneReg && !pending && (bit_cnt == '0);

  always_comb begin
    accept    = consume_en && window_valid && !start && !reset;
    acceptLen = accept ? clipLen(consume_len, bit_cnt) : '0;
    // Room check counts bits left after this cycle's consume plus every word still in flight.
    committed = 7'(bit_cnt) - 7'(acceptLen) + (pending ? 7'(BS_WORD_W) : 7'd0) + 7'(BS_WORD_W);
    issue     = (state == FETCH) && !start && !reset && (committed <= 7'(BS_BUF_W));
    lastIssue = issue && (addrReg == LAST_ADDR);

    stateNext = state;
    case (state)
      IDLE:    stateNext = IDLE;
      FETCH:   if (lastIssue) stateNext = DRAIN;
      DRAIN:   if (stream_end) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (start) stateNext = FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      doneReg <= 1'b0;
      addrReg <= '0;
    end else begin
      state <= stateNext;
      if (start) begin
        pending <= 1'b0;
        doneReg <= 1'b0;
        addrReg <= start_addr;
      end else begin
        pending <= issue;
        if (lastIssue) doneReg <= 1'b1;
        else if (issue) addrReg <= addrReg + 1'b1;
      end
    end
  end

  bs_shift_buffer u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .shiftLen   (acceptLen),
    .insertEn   (pending && !start),
    .insertWord (BitStream_ram_data),
    .window     (bits_window),
    .bitCnt     (bit_cnt)
  );

  assign BitStream_ram_ren  = ~issue;
  assign BitStream_ram_addr = addrReg;
  assign fetch_done         = doneReg;

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Scoreboard bench for bitstream_fetch_ctrl against a bit-queue reference model.
module tb_bitstream_fetch_ctrl;

  localparam int unsigned AW      = 17;
  localparam logic [16:0] TB_LAST = 17'h140;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] start_addr;
  logic        ramRen;
  logic [16:0] ramAddr;
  logic [15:0] ramData;
  logic [15:0] bitsWindow;
  logic        windowValid;
  logic        consumeEn;
  logic [4:0]  consumeLen;
  logic [5:0]  bitCnt;
  logic        fetchDone;
  logic        streamEnd;

  always #5 clk = ~clk;

  bitstream_fetch_ctrl #(.ADDR_W(AW), .LAST_ADDR(TB_LAST)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .start_addr         (start_addr),
    .BitStream_ram_ren  (ramRen),
    .BitStream_ram_addr (ramAddr),
    .BitStream_ram_data (ramData),
    .bits_window        (bitsWindow),
    .window_valid       (windowValid),
    .consume_en         (consumeEn),
    .consume_len        (consumeLen),
    .bit_cnt            (bitCnt),
    .fetch_done         (fetchDone),
    .stream_end         (streamEnd)
  );

  // RAM model: one-cycle read latency; garbage on the bus when no read was made.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) ramData <= (ramRen == 1'b0) ? mem[ramAddr] : 16'($urandom);

  typedef struct {
    logic        ren;
    logic [16:0] addr;
    logic [15:0] win;
    logic        valid;
    logic [5:0]  cnt;
    logic        done;
    logic        send;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: buffered bits as a queue, oldest first.
  bit          mBits[$];
  bit          mPend;
  bit          mDone;
  bit          mFetching;
  logic [16:0] mAddr;
  logic [16:0] mPendAddr;

  task automatic modelClear();
    mBits.delete();
    mPend = 0;
    mDone = 0;
  endtask

  task automatic step(input bit rst, input bit st, input logic [16:0] sa,
                      input bit ce, input int cl);
    exp_t e;
    int   cnt, acc;
    bit   iss;
    reset      = rst;
    start      = st;
    start_addr = sa;
    consumeEn  = ce;
    consumeLen = 5'(cl);
    cnt     = mBits.size();
    e.addr  = mAddr;
    e.cnt   = 6'(cnt);
    e.done  = mDone;
    e.valid = (cnt >= 16) || (mDone && cnt > 0);
    e.send  = mDone && !mPend && cnt == 0;
    for (int i = 0; i < 16; i++) e.win[15-i] = (i < cnt) ? mBits[i] : 1'b0;
    acc = 0;
    if (!rst && !st && ce && e.valid) begin
      acc = cl;
      if (acc > 16) acc = 16;
      if (acc > cnt) acc = cnt;
    end
    iss   = !rst && !st && mFetching && (cnt - acc + 16*int'(mPend) + 16 <= 48);
    e.ren = !iss;
    expQ.push_back(e);
    if (rst) begin
      modelClear();
      mFetching = 0;
      mAddr     = '0;
    end else if (st) begin
      modelClear();
      mFetching = 1;
      mAddr     = sa;
    end else begin
      for (int i = 0; i < acc; i++) mBits.delete(0);
      if (mPend) for (int b = 15; b >= 0; b--) mBits.push_back(mem[mPendAddr][b]);
      mPend     = iss;
      mPendAddr = mAddr;
      if (iss) begin
        if (mAddr == TB_LAST) begin
          mDone     = 1;
          mFetching = 0;
        end else begin
          mAddr = mAddr + 17'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      vectors++;
      chk("ren",          32'(ramRen),      32'(e.ren));
      chk("addr",         32'(ramAddr),     32'(e.addr));
      chk("window_valid", 32'(windowValid), 32'(e.valid));
      chk("bits_window",  32'(bitsWindow),  32'(e.win));
      chk("bit_cnt",      32'(bitCnt),      32'(e.cnt));
      chk("fetch_done",   32'(fetchDone),   32'(e.done));
      chk("stream_end",   32'(streamEnd),   32'(e.send));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[0]           = 16'h1234;
    mem[1]           = 16'hABCD;
    mem[TB_LAST-2]   = 16'h1111;
    mem[TB_LAST-1]   = 16'h2222;
    mem[TB_LAST]     = 16'h3333;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    consumeEn  = 1'b0;
    consumeLen = '0;
    repeat (2) @(posedge clk);
    #1;
    modelClear();
    mFetching = 0;
    mAddr     = '0;

    // reset state and idle: no reads before start
    step(1, 0, '0, 0, 0);
    idle(3);

    // basic fetch: three reads, then the buffer is full
    step(0, 1, 17'h0, 0, 0);
    idle(5);

    // unaligned consume 4 then 12
    step(0, 0, '0, 1, 4);
    step(0, 0, '0, 1, 12);
    idle(1);

    // steady state: consume 16 every cycle
    for (int i = 0; i < 40; i++) step(0, 0, '0, 1, 16);

    // end of stream: last three words, drain to a 5-bit tail, clip, empty
    step(0, 1, TB_LAST - 17'd2, 0, 0);
    idle(6);
    step(0, 0, '0, 1, 16);
    step(0, 0, '0, 1, 16);
    step(0, 0, '0, 1, 11);
    idle(1);
    step(0, 0, '0, 1, 16);
    idle(3);
    step(0, 0, '0, 1, 16);

    // restart while a read is pending, then reset mid-burst
    step(0, 1, 17'h0, 0, 0);
    idle(1);
    step(0, 1, 17'h100, 1, 8);
    idle(4);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 16);
    step(1, 0, '0, 1, 16);
    idle(2);

    // randomized traffic with occasional restarts and resets
    step(0, 1, 17'($urandom_range(0, int'(TB_LAST))), 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)      step(1, 0, '0, 1, 16);
      else if (r < 6) step(0, 1, 17'($urandom_range(int'(TB_LAST) - 8, int'(TB_LAST))), 1, 16);
      else if (r < 8) step(0, 1, 17'($urandom_range(0, int'(TB_LAST))), 0, 0);
      else            step(0, 0, '0, $urandom_range(0, 3) != 0, $urandom_range(0, 31));
    end
    idle(2);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
